// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling FSM,
// one-cycle strobes for a good byte (o_rx_complete) or a bad stop bit (o_rx_err).
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx_d,
  output logic [7:0] o_rx_d,
  output logic       o_rx_complete,
  output logic       o_rx_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic             r_rx_meta;
  logic             r_rx_s;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_sh;

  // NOTE: every flop uses <= so all registers update together from the
  // values present before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_rx_d;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_sh          <= '0;
      o_rx_d        <= '0;
      o_rx_complete <= 1'b0;
      o_rx_err      <= 1'b0;
    end else begin
      o_rx_complete <= 1'b0;
      o_rx_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_idx <= '0;
          if (!r_rx_s) r_state <= S_START;
        end

        // Re-check the line at the middle of the start bit to reject glitches.
        S_START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt   <= '0;
            r_state <= r_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt       <= '0;
            r_sh[r_idx] <= r_rx_s;
            if (r_idx == 3'd7) r_state <= S_STOP;
            else               r_idx   <= r_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // Leaving at mid-stop-bit lets a start bit right after it be caught.
        S_STOP: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              o_rx_d        <= r_sh;
              o_rx_complete <= 1'b1;
              r_state       <= S_IDLE;
            end else begin
              o_rx_err <= 1'b1;
              r_state  <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_BREAK: begin
          r_cnt <= '0;
          if (r_rx_s) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: hand sequences for reset, glitch, framing error,
// back-to-back and mid-frame reset, plus a table of frames at skewed baud rates.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB    = 434;
  localparam int HALF   = CPB / 2;
  localparam int LAT    = HALF + 9 * CPB;   // 4123 from entry to START
  localparam int FRAME  = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_rx_d = 1'b1;
  logic [7:0] o_rx_d;
  logic       o_rx_complete;
  logic       o_rx_err;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx_d       (i_rx_d),
    .o_rx_d       (o_rx_d),
    .o_rx_complete(o_rx_complete),
    .o_rx_err     (o_rx_err)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_complete = 0;
  int n_err = 0;
  int n_both = 0;
  int tx_done = 0;
  int last_start = 0;
  logic [7:0] got_q[$];
  int         stb_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor; counts high cycles so a stuck strobe shows up as extra pulses.
  always @(negedge clk) begin
    if (o_rx_complete) begin
      n_complete++;
      got_q.push_back(o_rx_d);
      stb_cyc_q.push_back(cyc);
    end
    if (o_rx_err) n_err++;
    if (o_rx_complete && o_rx_err) n_both++;
  end

  initial begin
    #(95000 * 20);
    $display("FAIL watchdog: simulation exceeded 95000 clocks");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    i_rx_d = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input int bclks, input logic stop_v);
    last_start = cyc;
    hold(1'b0, bclks);
    for (int i = 0; i < 8; i++) hold(data[i], bclks);
    hold(stop_v, bclks);
  endtask

  typedef struct {
    logic [7:0] data;
    int         bclks;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs[4];
  int   base;
  int   lat;
  int   gap;
  logic [7:0] lb_bytes[4];

  initial begin
    vecs[0] = '{data: 8'hC5, bclks: 417, exp_d: 8'hC5};  // sender ~4% fast
    vecs[1] = '{data: 8'h3A, bclks: 451, exp_d: 8'h3A};  // sender ~4% slow
    vecs[2] = '{data: 8'hFE, bclks: CPB, exp_d: 8'hFE};
    vecs[3] = '{data: 8'h7F, bclks: CPB, exp_d: 8'h7F};
    lb_bytes = '{8'h55, 8'hAA, 8'h01, 8'h80};

    // Reset held for 2 clocks.
    rst = 1'b1;
    settle(2);
    rst = 1'b0;
    settle(3);
    check("reset_rx_d", int'(o_rx_d), 0);
    check("reset_complete", int'(o_rx_complete), 0);
    check("reset_err", int'(o_rx_err), 0);

    // 0x55 with latency measured from the start edge (2 sync clocks + 1 to enter START).
    send_frame(8'h55, CPB, 1'b1);
    settle(2);
    check("f55_count", n_complete, 1);
    check("f55_data", int'(o_rx_d), 8'h55);
    check("f55_err", n_err, 0);
    lat = (stb_cyc_q.size() > 0) ? stb_cyc_q[0] - last_start : -1;
    check("f55_latency_in_window", int'(lat >= LAT && lat <= LAT + 5), 1);

    // Glitch of 100 clocks must be rejected, then 0xA3 arrives normally.
    hold(1'b0, 100);
    hold(1'b1, 400);
    settle(1);
    check("glitch_no_strobe", n_complete, 1);
    check("glitch_no_err", n_err, 0);
    send_frame(8'hA3, CPB, 1'b1);
    settle(2);
    check("fa3_count", n_complete, 2);
    check("fa3_data", int'(o_rx_d), 8'hA3);

    // Framing error: stop bit 0, line held low two more bit times.
    send_frame(8'h3C, CPB, 1'b0);
    hold(1'b0, 2 * CPB);
    settle(1);
    check("ferr_err_count", n_err, 1);
    check("ferr_no_complete", n_complete, 2);
    check("ferr_data_held", int'(o_rx_d), 8'hA3);
    hold(1'b1, CPB);
    check("ferr_quiet_after_rise", n_err + n_complete, 3);
    send_frame(8'h0F, CPB, 1'b1);
    settle(2);
    check("f0f_count", n_complete, 3);
    check("f0f_data", int'(o_rx_d), 8'h0F);
    check("f0f_err", n_err, 1);

    // Back-to-back 0x00 then 0xFF with no idle between frames.
    base = got_q.size();
    send_frame(8'h00, CPB, 1'b1);
    send_frame(8'hFF, CPB, 1'b1);
    settle(2);
    check("b2b_count", n_complete, 5);
    if (got_q.size() >= base + 2) begin
      check("b2b_first", int'(got_q[base]), 8'h00);
      check("b2b_second", int'(got_q[base + 1]), 8'hFF);
      gap = stb_cyc_q[base + 1] - stb_cyc_q[base];
      check("b2b_gap_in_window", int'(gap >= FRAME - 1 && gap <= FRAME + 1), 1);
    end
    check("b2b_data", int'(o_rx_d), 8'hFF);

    // Reset for one clock in the middle of data bit 4 of a 0xF0 frame.
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(1'b0, CPB);
    hold(1'b1, CPB / 2);
    rst = 1'b1;
    hold(1'b1, 1);
    rst = 1'b0;
    settle(1);
    check("rst_mid_rx_d", int'(o_rx_d), 0);
    hold(1'b1, CPB / 2 + 4 * CPB);
    check("rst_mid_no_strobe", n_complete, 5);
    check("rst_mid_no_err", n_err, 1);
    check("rst_mid_rx_d_held", int'(o_rx_d), 0);
    send_frame(8'h81, CPB, 1'b1);
    settle(2);
    check("f81_count", n_complete, 6);
    check("f81_data", int'(o_rx_d), 8'h81);

    // Table of frames, including +/-4% baud skew.
    for (int v = 0; v < 4; v++) begin
      base = n_complete;
      send_frame(vecs[v].data, vecs[v].bclks, 1'b1);
      hold(1'b1, 5);
      check($sformatf("vec%0d_count", v), n_complete - base, 1);
      check($sformatf("vec%0d_data", v), int'(o_rx_d), int'(vecs[v].exp_d));
      check($sformatf("vec%0d_err", v), n_err, 1);
    end

    // Loopback from a bench-side transmitter, frames back to back.
    base = got_q.size();
    for (int i = 0; i < 4; i++) begin
      send_frame(lb_bytes[i], CPB, 1'b1);
      tx_done++;
    end
    settle(2);
    check("loop_count", got_q.size() - base, tx_done);
    for (int i = 0; i < 4; i++)
      if (got_q.size() > base + i)
        check($sformatf("loop_byte%0d", i), int'(got_q[base + i]), int'(lb_bytes[i]));

    check("never_both_strobes", n_both, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that deserialises an asynchronous 8N1 serial line into parallel bytes. It is the receive-side counterpart of the existing UART Tx block and uses the same frame format: start bit 0, 8 data bits LSB first, stop bit 1, 115200 baud from a 50 MHz system clock. It sits between the external RX pin and the byte-consuming logic, and produces a one-cycle strobe per received byte plus a framing-error strobe.

## Interface
- CLKS_PER_BIT, 434, system clocks per bit period (50 MHz / 115200, truncated); must be ≥ 4.
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- i_rx_d  input  1  asynchronous serial line; idles high.
- o_rx_d  output  8  last correctly received byte; holds until the next good frame.
- o_rx_complete  output  1  one-cycle pulse when o_rx_d is updated.
- o_rx_err  output  1  one-cycle pulse on a framing error (stop bit sampled 0).

## Operation
- Input synchroniser: two flops on i_rx_d produce rx_s. Both reset to 1. Only rx_s is used internally.
- Counters and widths:
  - bit-period counter cnt: width clog2(CLKS_PER_BIT).
  - bit index idx: 3 bits.
  - shift register sh: 8 bits.
  - HALF = CLKS_PER_BIT/2 (integer division; 217 at default).
- IDLE: cnt=0, idx=0. If rx_s==0, go to START.
- START: cnt increments every cycle. When cnt==HALF-1, rx_s is sampled:
  - rx_s==0: go to DATA, cnt=0 (valid start).
  - rx_s==1: go to IDLE (false start or glitch); no outputs.
- DATA: cnt increments. When cnt==CLKS_PER_BIT-1:
  - sh[idx] ← rx_s (LSB first), cnt=0.
  - idx==7: go to STOP; otherwise idx+1.
- STOP: when cnt==CLKS_PER_BIT-1, rx_s is sampled:
  - rx_s==1: o_rx_d ← sh, o_rx_complete=1 for one cycle, go to IDLE.
  - rx_s==0: o_rx_err=1 for one cycle, o_rx_d unchanged, go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. A held-low line never produces further frames or errors.
- Sampling therefore lands mid-bit for every bit after the start bit.
- Outputs are registered. o_rx_complete and o_rx_err are never high in the same cycle.

## Timing
- Reset values:
  - o_rx_d=8'h00, o_rx_complete=0, o_rx_err=0.
  - State IDLE; cnt, idx and sh all 0.
  - Synchroniser flops at 1.
- rst dominates every state. Reset mid-frame aborts the frame with no strobe; reception resumes at the next falling edge after rst deasserts.
- Latency: the falling edge of i_rx_d reaches rx_s after 2 clocks. The output strobe is asserted HALF + 9·CLKS_PER_BIT cycles after entry to START (±1 clk for edge phase), i.e. 4123 cycles at default, about 82.5 µs.
- Back-to-back frames: the return to IDLE happens at mid-stop-bit, so a start bit immediately following the stop bit is detected. No idle time between frames is required.
- Tolerance: combined baud mismatch of up to ±4% (sender vs. CLKS_PER_BIT) must still yield correct bytes.
- Any change to i_rx_d while the receiver is in DATA or STOP has no effect except at the sample instants.

## Test plan
- Reset and 0x55: hold rst 2 clocks, then drive one 8N1 frame of 0x55 at 8680 ns/bit. Required: exactly one o_rx_complete pulse about 4123 clocks after the start edge, o_rx_d=8'h55, o_rx_err never high.
- Glitch rejection: drive i_rx_d low for 100 clocks, then high. Required: return to IDLE, no strobe. A following 0xA3 frame then gives o_rx_d=8'hA3.
- Framing error: send 0x3C with the stop bit driven 0 and the line then held low for 2 bit times. Required: a single o_rx_err pulse, o_rx_d still holds the prior value, and no further strobes until the line rises. A subsequent 0x0F frame is received correctly.
- Back-to-back: send 0x00 then 0xFF with no idle gap. Required: two o_rx_complete pulses 10·CLKS_PER_BIT ±1 clocks apart, with o_rx_d=8'h00 then 8'hFF.
- Reset mid-frame: assert rst for 1 clock during data bit 4 of a frame. Required: no strobe for that frame, outputs return to their reset values. A next frame of 0x81 gives o_rx_d=8'h81.
- Loopback: connect the UART Tx o_tx_d to i_rx_d and send 0x55, 0xAA, 0x01, 0x80. Required: each byte appears on o_rx_d in order, with one o_rx_complete per o_tx_complete.
